ram_sp_param: RTL and testbench
===============================

RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WRITE_MODE, default 0, write-port read behaviour: 0 write-first, 1 read-first, 2 no-change.
REQ-004 SHALL have parameter OUT_REG, default 0, extra output register stage: 0 none, 1 one stage.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill every word after reset when 1.
REQ-006 SHALL have port clka, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rsta, input, 1, synchronous active-high reset.
REQ-008 SHALL have port ena, input, 1, access enable.
REQ-009 SHALL have port wea, input, 1, write enable, qualified by ena.
REQ-010 SHALL have port addra, input, ADDR_WIDTH, access address.
REQ-011 SHALL have port dina, input, DATA_WIDTH, write data.
REQ-012 SHALL have port douta, output, DATA_WIDTH, read data.
REQ-013 SHALL have port douta_valid, output, 1, one-cycle pulse marking new douta.
REQ-014 SHALL have port busy, output, 1, high while the clear sweep runs; accesses are ignored.

Function
REQ-015 SHALL accept an access on an edge with ena=1, busy=0, rsta=0; other edges leave array, douta and pipeline contents unchanged.
REQ-016 SHALL write dina to mem[addra] on an accepted access with wea=1.
REQ-017 SHALL produce a read result for every accepted access: wea=0 gives mem[addra]; wea=1 gives dina (mode 0), the old mem[addra] (mode 1), or no douta update and no douta_valid (mode 2).
REQ-018 SHALL have latency 1 + OUT_REG: result on douta, with douta_valid=1, exactly that many edges after acceptance.
REQ-019 SHALL hold douta at its last value between results; douta_valid SHALL be high for one cycle per result.
REQ-020 SHALL use a two-state FSM: CLEAR (busy=1, writes 0 to mem[clr_addr], clr_addr+1 each edge) and IDLE (busy=0).
REQ-021 SHALL go CLEAR -> IDLE on the edge that writes address 2**ADDR_WIDTH-1; clr_addr has ADDR_WIDTH+1 bits so it cannot wrap.
REQ-022 SHALL not enter CLEAR when CLEAR_ON_RESET=0; reset goes straight to IDLE and array contents are undefined.
REQ-023 SHALL not complete an access whose result is still in the pipeline when rsta is asserted; the pipeline is flushed.
REQ-024 SHALL accept back-to-back accesses every cycle, including read-after-write to the same address on the next edge, which returns the new data.

Reset
REQ-025 SHALL on an edge with rsta=1 set douta=0, douta_valid=0, pipeline valid flags=0, clr_addr=0, and state CLEAR (IDLE if CLEAR_ON_RESET=0).
REQ-026 SHALL restart the sweep at address 0 if rsta is asserted during CLEAR.
REQ-027 SHALL keep busy=1 for exactly 2**ADDR_WIDTH edges after rsta deasserts when CLEAR_ON_RESET=1.

Structure
REQ-028 SHALL take the WRITE_MODE encodings (WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=0b10) and FSM state typedef from shared package ram_pkg.
REQ-029 SHALL place the storage array and write-mode read mux in sub-module ram_core; the FSM, clear counter and output pipeline stay at top level.

Verification
REQ-030 SHALL verify clear: reset 1 cycle (DW=8, AW=4) -> busy high 16 cycles; then reads of addr 0..15 all return 0x00.
REQ-031 SHALL verify basic R/W: write 0xA5 to addr 3, read addr 3 next cycle -> douta=0xA5 with valid 1 edge later (OUT_REG=0) or 2 edges later (OUT_REG=1).
REQ-032 SHALL verify write modes: mem[5]=0x11, then write 0x22 to addr 5 -> douta 0x22 (mode 0), 0x11 (mode 1), unchanged with no valid (mode 2).
REQ-033 SHALL verify busy blocking: write 0xFF to addr 2 while busy=1 -> after clear, read addr 2 = 0x00 and no douta_valid during busy.
REQ-034 SHALL verify reset mid-operation: rsta at sweep address 9, then again with a read in flight -> sweep restarts at 0 (16 busy cycles) and the in-flight read produces no douta_valid.
REQ-035 SHALL verify streaming: a 16-cycle continuous write of addr i with data i*3, then a continuous read -> 16 consecutive valid pulses with data 0x00,0x03,...,0x2D.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared write-mode encodings and controller state type for ram_sp_param
package ram_pkg;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_core.sv
// rtl/ram_core.sv - storage array with write-mode dependent read result mux
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WRITE_MODE = WM_WRITE_FIRST
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ok
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // The array read is pre-write, so read-first needs no special case.
    always_comb begin
        rd_data = mem[addr];
        rd_ok   = 1'b1;
        if (we) begin
            if (WRITE_MODE == WM_WRITE_FIRST) begin
                rd_data = din;
            end else if (WRITE_MODE == WM_NO_CHANGE) begin
                rd_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram_sp_param.sv
// rtl/ram_sp_param.sv - single-port RAM with clear sweep, write modes and optional output register
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int WRITE_MODE     = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  douta_valid,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   clr_addr;
    logic                  accept;
    logic                  clr_we;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_din;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ok;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign accept    = ena && !busy && !rsta;
    assign clr_we    = (state == ST_CLEAR) && !rsta;
    assign core_we   = clr_we || (accept && wea);
    assign core_addr = clr_we ? clr_addr[ADDR_WIDTH-1:0] : addra;
    assign core_din  = clr_we ? '0 : dina;

    ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .WRITE_MODE(WRITE_MODE)
    ) u_core (
        .clk    (clka),
        .we     (core_we),
        .addr   (core_addr),
        .din    (core_din),
        .rd_data(rd_data),
        .rd_ok  (rd_ok)
    );

    always_ff @(posedge clka) begin
        if (rsta) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy     <= (CLEAR_ON_RESET != 0);
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == CLR_LAST) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept && rd_ok;
            if (accept && rd_ok) begin
                s1_data <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clka) begin
                if (rsta) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign douta       = s2_data;
            assign douta_valid = s2_valid;
        end else begin : g_no_out_reg
            assign douta       = s1_data;
            assign douta_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sp_param.sv
// tb/tb_ram_sp_param.sv - self-checking bench for ram_sp_param across three configurations
module tb_ram_sp_param;

    logic       clk = 1'b0;
    logic       rsta, ena, wea;
    logic [3:0] addra;
    logic [7:0] dina;
    logic [7:0] do0, do1, do2;
    logic       dv0, dv1, dv2, b0, b1, b2;
    logic [29:0] act;

    always #5 clk = ~clk;

    // dut0: write-first, no out reg; dut1: read-first, out reg; dut2: no-change, no out reg
    ram_sp_param #(.WRITE_MODE(0), .OUT_REG(0)) dut0 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(do0), .douta_valid(dv0), .busy(b0));
    ram_sp_param #(.WRITE_MODE(1), .OUT_REG(1)) dut1 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(do1), .douta_valid(dv1), .busy(b1));
    ram_sp_param #(.WRITE_MODE(2), .OUT_REG(0)) dut2 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(do2), .douta_valid(dv2), .busy(b2));

    assign act = {b0, b1, b2, dv0, dv1, dv2, do0, do1, do2};

    typedef struct {
        int         due;
        logic [7:0] d;
    } res_t;

    res_t       pend [3][$];
    logic [7:0] mem_m [16];
    logic [7:0] last [3];
    logic       ev [3];
    int         mode_k [3] = '{0, 1, 2};
    int         extra_k [3] = '{0, 1, 0};
    int         busy_left = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic logic [29:0] exp_vec();
        logic bz;
        bz = (busy_left > 0);
        return {bz, bz, bz, ev[0], ev[1], ev[2], last[0], last[1], last[2]};
    endfunction

    // Applies one cycle of inputs and advances the reference model past that edge.
    task automatic drive(input logic rst, input logic en, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
        logic [7:0] old;
        res_t r;
        rsta = rst; ena = en; wea = we; addra = a; dina = d;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            busy_left = 16;
            for (int k = 0; k < 3; k++) begin
                pend[k].delete();
                last[k] = 8'h00;
            end
        end else if (busy_left > 0) begin
            mem_m[16 - busy_left] = 8'h00;
            busy_left--;
        end else if (en) begin
            old = mem_m[a];
            if (we) mem_m[a] = d;
            for (int k = 0; k < 3; k++) begin
                r.due = cyc + extra_k[k];
                if (!we) begin
                    r.d = old;
                    pend[k].push_back(r);
                end else if (mode_k[k] == 0) begin
                    r.d = d;
                    pend[k].push_back(r);
                end else if (mode_k[k] == 1) begin
                    r.d = old;
                    pend[k].push_back(r);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            if (pend[k].size() > 0 && pend[k][0].due == cyc) begin
                last[k] = pend[k][0].d;
                ev[k]   = 1'b1;
                void'(pend[k].pop_front());
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++; $display("FAIL reset_state cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
        end
        cnt = 0;
        for (int i = 0; i < 40 && b0 === 1'b1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            cnt++;
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL clear_sweep cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        n_checks++;
        if (cnt !== 16) begin
            n_fail++; $display("FAIL clear_busy_len got=%0d want=16", cnt);
        end
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, i < 16, 1'b0, 4'(i), 8'h00);
            n_checks++;
            if (act !== exp_vec() || (i < 16 && (dv0 !== 1'b1 || do0 !== 8'h00))) begin
                n_fail++; $display("FAIL clear_readback addr=%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_basic_rw();
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++; $display("FAIL basic_write act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        n_checks++;
        if (act !== exp_vec() || dv0 !== 1'b1 || do0 !== 8'hA5) begin
            n_fail++; $display("FAIL basic_read_lat1 act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec() || dv1 !== 1'b1 || do1 !== 8'hA5 || dv0 !== 1'b0 || do0 !== 8'hA5) begin
            n_fail++; $display("FAIL basic_read_lat2 act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++; $display("FAIL basic_hold act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_write_modes();
        logic [7:0] prev2;
        drive(1'b0, 1'b1, 1'b1, 4'd5, 8'h11);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        prev2 = do2;
        drive(1'b0, 1'b1, 1'b1, 4'd5, 8'h22);
        n_checks++;
        if (act !== exp_vec() || do0 !== 8'h22 || dv0 !== 1'b1 || dv2 !== 1'b0 || do2 !== prev2) begin
            n_fail++; $display("FAIL write_mode_0_2 act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec() || do1 !== 8'h11 || dv1 !== 1'b1) begin
            n_fail++; $display("FAIL write_mode_1 act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
        n_checks++;
        if (act !== exp_vec() || do2 !== 8'h22) begin
            n_fail++; $display("FAIL write_mode_readback act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_busy_block();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 40 && b0 === 1'b1; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'd2, 8'hFF);
            n_checks++;
            if (act !== exp_vec() || dv0 !== 1'b0 || dv1 !== 1'b0) begin
                n_fail++; $display("FAIL busy_block cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        drive(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
        n_checks++;
        if (act !== exp_vec() || dv0 !== 1'b1 || do0 !== 8'h00) begin
            n_fail++; $display("FAIL busy_block_read act=%h exp=%h", act, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic test_reset_mid();
        int cnt;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        cnt = 0;
        for (int i = 0; i < 40 && b0 === 1'b1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            cnt++;
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL reset_mid_sweep cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        n_checks++;
        if (cnt !== 16) begin
            n_fail++; $display("FAIL reset_mid_busy_len got=%0d want=16", cnt);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec() || dv1 !== 1'b0 || do1 !== 8'h00) begin
            n_fail++; $display("FAIL reset_flush act=%h exp=%h", act, exp_vec());
        end
        for (int i = 0; i < 40 && b0 === 1'b1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL reset_flush_sweep cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_stream();
        int pulses;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'(i), 8'(i * 3));
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL stream_write i=%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            if (dv0 === 1'b1) pulses++;
            n_checks++;
            if (act !== exp_vec() || do0 !== 8'(i * 3)) begin
                n_fail++; $display("FAIL stream_read i=%0d act=%h exp=%h", i, act, exp_vec());
            end
        end
        n_checks++;
        if (pulses !== 16) begin
            n_fail++; $display("FAIL stream_pulses got=%0d want=16", pulses);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        n_checks++;
        if (act !== exp_vec() || do1 !== 8'h2D) begin
            n_fail++; $display("FAIL stream_tail act=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  4'($urandom), 8'($urandom));
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
    endtask

    initial begin
        rsta = 1'b0; ena = 1'b0; wea = 1'b0; addra = 4'd0; dina = 8'h00;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            last[k] = 8'h00;
            ev[k]   = 1'b0;
        end
        test_reset();
        test_basic_rw();
        test_write_modes();
        test_busy_block();
        test_reset_mid();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
